// File: rtl/bumpstop_ctrl.sv
// Bump-stop robot motion controller. Debounces the bumpers and sequences
// drive / stop / reverse / turn, producing per-wheel PWM on-time, enable and direction.
module bumpstop_ctrl #(
    parameter int CLK_PER_MS  = 16000,
    parameter int DEBOUNCE_MS = 10,
    parameter int CRUISE      = 12000,
    parameter int RAMP_STEP   = 400,
    parameter int REV_SPEED   = 8000,
    parameter int STOP_MS     = 100,
    parameter int REV_MS      = 500,
    parameter int TURN_MS     = 400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic        bump_l,
    input  logic        bump_r,
    output logic [15:0] timeon_l,
    output logic [15:0] timeon_r,
    output logic        motor_en_l,
    output logic        motor_en_r,
    output logic        dir_l,
    output logic        dir_r,
    output logic [2:0]  state,
    output logic [7:0]  bump_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRIVE   = 3'd1,
        STOP    = 3'd2,
        REVERSE = 3'd3,
        TURN    = 3'd4
    } stateT;

    localparam int TickW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int DbW   = $clog2(DEBOUNCE_MS + 1);
    localparam logic [TickW-1:0] TickLast = TickW'(CLK_PER_MS - 1);
    localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_MS - 1);
    localparam logic [15:0]      RevSpeed = 16'(REV_SPEED);
    localparam logic [15:0]      StopLast = 16'(STOP_MS - 1);
    localparam logic [15:0]      RevLast  = 16'(REV_MS - 1);
    localparam logic [15:0]      TurnLast = 16'(TURN_MS - 1);

    logic [TickW-1:0] tickCnt_q;
    logic             tick;
    logic [1:0]       sync1_q, sync2_q, db_q, evt_q;
    logic [DbW-1:0]   dbCnt_q [2];

    stateT       state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] timeonL_q, timeonL_d, timeonR_q, timeonR_d;
    logic        en_q, en_d, dirL_q, dirL_d, dirR_q, dirR_d;
    logic        sideLeft_q, sideLeft_d;
    logic [7:0]  bumpCnt_q, bumpCnt_d;
    logic [16:0] rampSum;
    logic [15:0] rampNext;
    logic        bumpEvt;

    assign tick = (tickCnt_q == TickLast);

    always_ff @(posedge clk) begin
        if (reset) begin
            tickCnt_q <= '0;
        end else if (tick) begin
            tickCnt_q <= '0;
        end else begin
            tickCnt_q <= tickCnt_q + 1'b1;
        end
    end

    // Index 0 is the left bumper, index 1 the right; a debounced rising edge becomes a one-cycle event.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            evt_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                dbCnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= {bump_r, bump_l};
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                evt_q[i] <= 1'b0;
                if (sync2_q[i] == db_q[i]) begin
                    dbCnt_q[i] <= '0;
                end else if (tick) begin
                    if (dbCnt_q[i] == DbLast) begin
                        db_q[i]    <= sync2_q[i];
                        dbCnt_q[i] <= '0;
                        evt_q[i]   <= sync2_q[i];
                    end else begin
                        dbCnt_q[i] <= dbCnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign bumpEvt  = |evt_q;
    assign rampSum  = {1'b0, timeonL_q} + 17'(RAMP_STEP);
    assign rampNext = (rampSum > 17'(CRUISE)) ? 16'(CRUISE) : rampSum[15:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            timeonL_q  <= '0;
            timeonR_q  <= '0;
            en_q       <= 1'b0;
            dirL_q     <= 1'b1;
            dirR_q     <= 1'b1;
            sideLeft_q <= 1'b0;
            bumpCnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            timeonL_q  <= timeonL_d;
            timeonR_q  <= timeonR_d;
            en_q       <= en_d;
            dirL_q     <= dirL_d;
            dirR_q     <= dirR_d;
            sideLeft_q <= sideLeft_d;
            bumpCnt_q  <= bumpCnt_d;
        end
    end

    // Every state change zeroes on-time for a cycle, so direction only ever flips with the motors unpowered.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        timeonL_d  = timeonL_q;
        timeonR_d  = timeonR_q;
        en_d       = en_q;
        dirL_d     = dirL_q;
        dirR_d     = dirR_q;
        sideLeft_d = sideLeft_q;
        bumpCnt_d  = bumpCnt_q;
        if (tick) begin
            timer_d = timer_q + 16'd1;
        end
        case (state_q)
            IDLE: begin
                if (go) state_d = DRIVE;
            end
            DRIVE: begin
                if (bumpEvt) begin
                    state_d    = STOP;
                    sideLeft_d = db_q[0];
                    if (bumpCnt_q != 8'hFF) bumpCnt_d = bumpCnt_q + 8'd1;
                end else if (tick) begin
                    timeonL_d = rampNext;
                    timeonR_d = rampNext;
                end
            end
            STOP: begin
                if (tick && timer_q == StopLast) state_d = REVERSE;
            end
            REVERSE: begin
                timeonL_d = RevSpeed;
                timeonR_d = RevSpeed;
                if (tick && timer_q == RevLast) state_d = TURN;
            end
            TURN: begin
                timeonL_d = RevSpeed;
                timeonR_d = RevSpeed;
                if (tick && timer_q == TurnLast) state_d = DRIVE;
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && !go) begin
            state_d    = IDLE;
            sideLeft_d = sideLeft_q;
            bumpCnt_d  = bumpCnt_q;
        end
        if (state_d != state_q) begin
            timer_d   = '0;
            timeonL_d = '0;
            timeonR_d = '0;
            en_d      = (state_d != IDLE);
            case (state_d)
                REVERSE: begin
                    dirL_d = 1'b0;
                    dirR_d = 1'b0;
                end
                TURN: begin
                    dirL_d = sideLeft_q;
                    dirR_d = ~sideLeft_q;
                end
                default: begin
                    dirL_d = 1'b1;
                    dirR_d = 1'b1;
                end
            endcase
        end
    end

    assign timeon_l   = timeonL_q;
    assign timeon_r   = timeonR_q;
    assign motor_en_l = en_q;
    assign motor_en_r = en_q;
    assign dir_l      = dirL_q;
    assign dir_r      = dirR_q;
    assign state      = state_q;
    assign bump_count = bumpCnt_q;

endmodule

// File: tb/tb_bumpstop_ctrl.sv
// Directed bench for bumpstop_ctrl with shortened timing (10-cycle tick), checked by immediate assertions.
// cyc counts rising edges since the last reset edge; tick-driven updates land on multiples of 10.
module tb_bumpstop_ctrl;

    logic        clk = 1'b0;
    logic        reset, go, bump_l, bump_r;
    logic [15:0] timeon_l, timeon_r;
    logic        motor_en_l, motor_en_r, dir_l, dir_r;
    logic [2:0]  state;
    logic [7:0]  bump_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int expCount = 0;

    always #5 clk = ~clk;

    bumpstop_ctrl #(
        .CLK_PER_MS(10), .DEBOUNCE_MS(3), .CRUISE(1000), .RAMP_STEP(400),
        .REV_SPEED(800), .STOP_MS(2), .REV_MS(4), .TURN_MS(3)
    ) dut (
        .clk(clk), .reset(reset), .go(go), .bump_l(bump_l), .bump_r(bump_r),
        .timeon_l(timeon_l), .timeon_r(timeon_r),
        .motor_en_l(motor_en_l), .motor_en_r(motor_en_r),
        .dir_l(dir_l), .dir_r(dir_r), .state(state), .bump_count(bump_count)
    );

    task automatic stepN(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic stepTo(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic applyStimulus(input logic g, input logic bl, input logic br);
        go     = g;
        bump_l = bl;
        bump_r = br;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d cycle=%0d", tag, observed, expected, cyc);
        end
    endtask

    task automatic checkState(input string tag, input logic [2:0] expState);
        checkOutput({tag, "_state"}, 32'(state), 32'(expState));
    endtask

    task automatic checkTimeon(input string tag, input logic [15:0] expL, input logic [15:0] expR);
        checkOutput({tag, "_timeonL"}, 32'(timeon_l), 32'(expL));
        checkOutput({tag, "_timeonR"}, 32'(timeon_r), 32'(expR));
    endtask

    task automatic checkDrive(input string tag, input logic expEn, input logic expDirL, input logic expDirR);
        checkOutput({tag, "_enL"}, 32'(motor_en_l), 32'(expEn));
        checkOutput({tag, "_enR"}, 32'(motor_en_r), 32'(expEn));
        checkOutput({tag, "_dirL"}, 32'(dir_l), 32'(expDirL));
        checkOutput({tag, "_dirR"}, 32'(dir_r), 32'(expDirR));
    endtask

    task automatic checkCount(input string tag, input int expected);
        checkOutput({tag, "_count"}, 32'(bump_count), 32'(expected));
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        cyc = 0;
        checkState("rst", 3'd0);
        checkTimeon("rst", 16'd0, 16'd0);
        checkDrive("rst", 1'b0, 1'b1, 1'b1);
        checkCount("rst", 0);

        // Start and speed ramp
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepTo(1);
        checkState("go", 3'd1);
        checkTimeon("go", 16'd0, 16'd0);
        checkDrive("go", 1'b1, 1'b1, 1'b1);
        stepTo(9);   checkTimeon("ramp0", 16'd0, 16'd0);
        stepTo(10);  checkTimeon("ramp1", 16'd400, 16'd400);
        stepTo(20);  checkTimeon("ramp2", 16'd800, 16'd800);
        stepTo(30);  checkTimeon("ramp3", 16'd1000, 16'd1000);
        stepTo(40);  checkTimeon("ramp4", 16'd1000, 16'd1000);

        // Two-tick glitch must be rejected
        stepTo(45);  applyStimulus(1'b1, 1'b1, 1'b0);
        stepTo(65);  applyStimulus(1'b1, 1'b0, 1'b0);
        stepTo(80);
        checkState("glitch", 3'd1);
        checkCount("glitch", 0);
        checkTimeon("glitch", 16'd1000, 16'd1000);

        // Left bump: full stop / reverse / pivot-right / drive sequence
        stepTo(100); applyStimulus(1'b1, 1'b1, 1'b0);
        stepTo(130); checkState("preBump", 3'd1);
        stepTo(131);
        checkState("stop", 3'd2);
        checkTimeon("stop", 16'd0, 16'd0);
        checkDrive("stop", 1'b1, 1'b1, 1'b1);
        checkCount("stop", 1);
        stepTo(149); checkState("stopEnd", 3'd2);
        stepTo(150);
        checkState("revIn", 3'd3);
        checkTimeon("revIn", 16'd0, 16'd0);
        checkDrive("revIn", 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepTo(151); checkTimeon("rev", 16'd800, 16'd800);
        stepTo(189);
        checkState("revEnd", 3'd3);
        checkTimeon("revEnd", 16'd800, 16'd800);
        stepTo(190);
        checkState("turnInL", 3'd4);
        checkTimeon("turnInL", 16'd0, 16'd0);
        checkDrive("turnInL", 1'b1, 1'b1, 1'b0);
        stepTo(191); checkTimeon("turnL", 16'd800, 16'd800);
        stepTo(219); checkState("turnEndL", 3'd4);
        stepTo(220);
        checkState("redrive", 3'd1);
        checkTimeon("redrive", 16'd0, 16'd0);
        checkDrive("redrive", 1'b1, 1'b1, 1'b1);
        checkCount("redrive", 1);
        stepTo(230); checkTimeon("reramp", 16'd400, 16'd400);

        // Right bump pivots left; a bump during REVERSE is ignored
        stepTo(240); applyStimulus(1'b1, 1'b0, 1'b1);
        stepTo(271);
        checkState("stopR", 3'd2);
        checkCount("stopR", 2);
        stepTo(275); applyStimulus(1'b1, 1'b0, 1'b0);
        stepTo(290); checkState("revR", 3'd3);
        stepTo(291); applyStimulus(1'b1, 1'b1, 1'b0);
        stepTo(321);
        checkState("revIgnore", 3'd3);
        checkCount("revIgnore", 2);
        stepTo(325); applyStimulus(1'b1, 1'b0, 1'b0);
        stepTo(329); checkState("revEndR", 3'd3);
        stepTo(330);
        checkState("turnInR", 3'd4);
        checkTimeon("turnInR", 16'd0, 16'd0);
        checkDrive("turnInR", 1'b1, 1'b0, 1'b1);
        checkCount("turnInR", 2);
        stepTo(331); checkTimeon("turnR", 16'd800, 16'd800);
        stepTo(360); checkState("driveR", 3'd1);

        // Both bumpers together count once and pivot right
        stepTo(380); applyStimulus(1'b1, 1'b1, 1'b1);
        stepTo(411);
        checkState("stopBoth", 3'd2);
        checkCount("stopBoth", 3);
        stepTo(415); applyStimulus(1'b1, 1'b0, 1'b0);
        stepTo(470);
        checkState("turnBoth", 3'd4);
        checkDrive("turnBoth", 1'b1, 1'b1, 1'b0);
        stepTo(500); checkState("driveBoth", 3'd1);

        // go dropped mid-REVERSE
        stepTo(510); applyStimulus(1'b1, 1'b1, 1'b0);
        stepTo(541); checkCount("stop4", 4);
        stepTo(545); applyStimulus(1'b1, 1'b0, 1'b0);
        stepTo(575);
        checkState("revAbort", 3'd3);
        checkTimeon("revAbort", 16'd800, 16'd800);
        applyStimulus(1'b0, 1'b0, 1'b0);
        stepTo(576);
        checkState("abort", 3'd0);
        checkTimeon("abort", 16'd0, 16'd0);
        checkDrive("abort", 1'b0, 1'b1, 1'b1);
        checkCount("abort", 4);

        stepTo(580); reset = 1'b1;
        stepTo(581);
        checkState("midRst", 3'd0);
        checkCount("midRst", 0);
        reset = 1'b0;

        // Saturation: bump in DRIVE, drop go to IDLE, release, re-arm
        expCount = 0;
        for (int i = 1; i <= 256; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            stepN(2);
            applyStimulus(1'b1, 1'b1, 1'b0);
            stepN(40);
            applyStimulus(1'b0, 1'b1, 1'b0);
            stepN(1);
            applyStimulus(1'b0, 1'b0, 1'b0);
            stepN(40);
            expCount = (expCount < 255) ? expCount + 1 : 255;
            if (i % 64 == 1 || i >= 254) checkCount($sformatf("sat%0d", i), expCount);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
